// File: rtl/avg8_ctrl_pkg.sv
// Shared types and sizing constants for the eight-operand averaging sequencer.
package avg8_ctrl_pkg;

  localparam int NUM_OPS    = 8;
  localparam int NUM_SHIFTS = 3;
  localparam int ACC_W      = 32;
  localparam int OP_W       = 16;
  localparam int SA_W       = 8;
  localparam int IDX_W      = $clog2(NUM_OPS);
  localparam int CNT_W      = $clog2(NUM_SHIFTS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/ADD.sv
// Generic unsigned adder, wrap-around at DATAWIDTH bits.
module ADD #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  output logic [DATAWIDTH-1:0] Sum
);

  assign Sum = A + B;

endmodule

// File: rtl/SHR.sv
// Generic logical right shifter; shift amounts >= DATAWIDTH give zero.
module SHR #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] Sh_amt,
  output logic [DATAWIDTH-1:0] D
);

  assign D = A >> Sh_amt;

endmodule

// File: rtl/avg8_dp.sv
// Datapath: captured operands and shift amount, accumulator, and the single
// shared adder/shifter pair driven by the sequencer's strobes.
module avg8_dp
  import avg8_ctrl_pkg::IDX_W;
  import avg8_ctrl_pkg::OP_W;
  import avg8_ctrl_pkg::SA_W;
#(
  parameter int NUM_OPS = 8,
  parameter int ACC_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             add_en_i,
  input  logic             shift_en_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  input  logic [OP_W-1:0]  c_i,
  input  logic [OP_W-1:0]  d_i,
  input  logic [OP_W-1:0]  e_i,
  input  logic [OP_W-1:0]  f_i,
  input  logic [OP_W-1:0]  g_i,
  input  logic [OP_W-1:0]  h_i,
  input  logic [SA_W-1:0]  sa_i,
  output logic [OP_W-1:0]  res_o
);

  logic [OP_W-1:0]  op_in [NUM_OPS];
  logic [OP_W-1:0]  op_q  [NUM_OPS];
  logic [SA_W-1:0]  sa_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] add_b;
  logic [ACC_W-1:0] shr_b;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] shr;

  assign op_in[0] = a_i;
  assign op_in[1] = b_i;
  assign op_in[2] = c_i;
  assign op_in[3] = d_i;
  assign op_in[4] = e_i;
  assign op_in[5] = f_i;
  assign op_in[6] = g_i;
  assign op_in[7] = h_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_op
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          op_q[gi] <= '0;
        end else if (load_i) begin
          op_q[gi] <= op_in[gi];
        end
      end
    end
  endgenerate

  // Zero extension keeps partial sums exact up to 8 * 0xFFFF.
  assign add_b = {{(ACC_W-OP_W){1'b0}}, op_q[idx_i]};
  assign shr_b = {{(ACC_W-SA_W){1'b0}}, sa_q};

  ADD #(.DATAWIDTH(ACC_W)) u_add (
    .A   (acc_q),
    .B   (add_b),
    .Sum (sum)
  );

  SHR #(.DATAWIDTH(ACC_W)) u_shr (
    .A      (acc_q),
    .Sh_amt (shr_b),
    .D      (shr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q  <= '0;
      acc_q <= '0;
    end else if (load_i) begin
      sa_q  <= sa_i;
      acc_q <= '0;
    end else if (add_en_i) begin
      acc_q <= sum;
    end else if (shift_en_i) begin
      acc_q <= shr;
    end
  end

  assign res_o = shr[OP_W-1:0];

endmodule

// File: rtl/avg8_seq_ctrl.sv
// Sequencer: accumulates eight captured operands, then applies three shifts by
// sa, publishing the low 16 bits as avg with a one-cycle done pulse.
module avg8_seq_ctrl #(
  parameter int NUM_OPS = 8,
  parameter int ACC_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [7:0]  sa,
  output logic        busy,
  output logic        done,
  output logic [15:0] avg
);

  import avg8_ctrl_pkg::state_e;
  import avg8_ctrl_pkg::ST_IDLE;
  import avg8_ctrl_pkg::ST_ACC;
  import avg8_ctrl_pkg::ST_SHIFT;
  import avg8_ctrl_pkg::IDX_W;
  import avg8_ctrl_pkg::CNT_W;
  import avg8_ctrl_pkg::NUM_SHIFTS;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [15:0]      avg_q, avg_d;
  logic             load, add_en, shift_en;
  logic [15:0]      res;

  avg8_dp #(
    .NUM_OPS (NUM_OPS),
    .ACC_W   (ACC_W)
  ) u_dp (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .add_en_i   (add_en),
    .shift_en_i (shift_en),
    .idx_i      (idx_q),
    .a_i        (a),
    .b_i        (b),
    .c_i        (c),
    .d_i        (d),
    .e_i        (e),
    .f_i        (f),
    .g_i        (g),
    .h_i        (h),
    .sa_i       (sa),
    .res_o      (res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      avg_q   <= avg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    avg_d    = avg_q;
    load     = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // abort outranks start, so a simultaneous pair launches nothing.
        if (start && !abort) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          add_en = 1'b1;
          idx_d  = idx_q + 1'b1;
          if (idx_q == IDX_W'(NUM_OPS - 1)) begin
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_SHIFTS - 1)) begin
            cnt_d   = '0;
            avg_d   = res;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign avg  = avg_q;

endmodule

// File: tb/tb_avg8_seq_ctrl.sv
// Directed bench for avg8_seq_ctrl: latency, arithmetic corners, back-to-back
// starts, ignored starts, abort and asynchronous reset.
module tb_avg8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] opv [8];
  logic [7:0]  sa;
  logic        busy;
  logic        done;
  logic [15:0] avg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  avg8_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .a     (opv[0]),
    .b     (opv[1]),
    .c     (opv[2]),
    .d     (opv[3]),
    .e     (opv[4]),
    .f     (opv[5]),
    .g     (opv[6]),
    .h     (opv[7]),
    .sa    (sa),
    .busy  (busy),
    .done  (done),
    .avg   (avg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 8; i++) opv[i] = v;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 8; i++) opv[i] = 16'(i + 1);
  endtask

  // Called at a negedge; returns at the negedge right after E0.
  task automatic launch(input logic [7:0] sa_v);
    sa    = sa_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [15:0] exp_avg);
    int lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    $display("op %s: latency=%0d avg=0x%04h", tag, lat, avg);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_avg"}, {16'h0, avg}, {16'h0, exp_avg});
  endtask

  task automatic watch(input int n, output int ndone);
    ndone = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  initial begin
    int nd;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sa    = 8'h0;
    set_all(16'h0);
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_avg", {16'h0, avg}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // ones, sa=1: 8 >> 3 = 1
    set_all(16'h0001);
    launch(8'd1);
    check("busy_after_start", {31'h0, busy}, 32'h1);
    wait_done("ones", 11, 16'h0001);
    watch(5, nd);
    check("ones_single_pulse", 32'(nd), 32'h0);
    check("idle_busy", {31'h0, busy}, 32'h0);

    // full scale: 0x7FFF8 >> 3 = 0xFFFF
    set_all(16'hFFFF);
    launch(8'd1);
    wait_done("full", 11, 16'hFFFF);

    // 0x7FFF8 >> 33 = 0, and a shift far past the width
    launch(8'd11);
    wait_done("sa11", 11, 16'h0000);
    launch(8'd255);
    wait_done("sa255", 11, 16'h0000);

    // ramp with sa=0, then a second start in the done cycle
    set_ramp();
    launch(8'd0);
    wait_done("ramp", 11, 16'd36);
    set_all(16'h0001);
    launch(8'd1);
    wait_done("b2b", 11, 16'h0001);

    // start re-raised at E4 with a changed operand: ignored
    set_ramp();
    launch(8'd0);
    repeat (3) @(negedge clk);
    start   = 1'b1;
    opv[0]  = 16'h1234;
    @(negedge clk);
    start   = 1'b0;
    wait_done("restart", 7, 16'd36);
    watch(15, nd);
    check("restart_one_done", 32'(nd), 32'h0);

    // abort sampled at E6: no done, avg keeps 36
    set_all(16'hFFFF);
    launch(8'd1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    watch(15, nd);
    check("abort_no_done", 32'(nd), 32'h0);
    check("abort_avg_kept", {16'h0, avg}, 32'd36);
    $display("op abort: avg=0x%04h", avg);

    // reset mid-SHIFT acts immediately, without a clock edge
    launch(8'd1);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    check("async_rst_avg", {16'h0, avg}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    watch(15, nd);
    check("rst_no_done", 32'(nd), 32'h0);
    $display("op reset: avg=0x%04h", avg);

    // first start after reset behaves normally
    set_all(16'h0001);
    launch(8'd1);
    wait_done("post_rst", 11, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avg8_seq_ctrl.md
AVG8_SEQ_CTRL -- requirements
Module: avg8_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_OPS, default 8: operand count, fixed at 8 for this revision.
REQ-002 SHALL have parameter ACC_W, default 32: accumulator and shifter width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to compute one average, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of an operation in progress.
REQ-007 SHALL have ports a, b, c, d, e, f, g, h  input  16 each  operands, captured on the accepted start.
REQ-008 SHALL have port sa  input  8  shift amount, captured on the accepted start.
REQ-009 SHALL have port busy  output  1  high while state is not IDLE.
REQ-010 SHALL have port done  output  1  registered one-cycle pulse when avg has been updated.
REQ-011 SHALL have port avg  output  16  registered result; holds its value until the next done.

Function
REQ-012 SHALL implement the states IDLE, ACC and SHIFT, using one shared 32-bit adder and one shared 32-bit shifter.
REQ-013 IDLE with start=1 at edge E0: SHALL capture a..h and sa into operand registers, set acc=0 and idx=0, and go to ACC.
REQ-014 ACC, edges E1..E8: SHALL compute acc <= acc + zero-extended op[idx], in order a through h, with idx incrementing; at E8 SHALL go to SHIFT with cnt=0.
REQ-015 Accumulation SHALL be at the full 32-bit width with no 16-bit truncation of partial sums, so the maximum sum 0x7FFF8 is exact.
REQ-016 SHIFT, edges E9..E11: SHALL compute acc <= acc >> zero-extended sa (logical shift); a shift of 32 or more SHALL yield 0.
REQ-017 At E11: SHALL set avg <= (acc >> sa)[15:0] and done <= 1, and go to IDLE.
REQ-018 Latency: done SHALL be high in the cycle following E11, i.e. 11 edges after start is sampled.
REQ-019 done SHALL be high for exactly one cycle per completed operation.
REQ-020 start SHALL be accepted in the cycle in which done is high, giving a throughput of one result per 11 cycles.
REQ-021 start while busy=1 SHALL be ignored, with no effect on operands, state or outputs.
REQ-022 abort=1 in ACC or SHIFT SHALL return to IDLE at the next edge, with no done pulse and avg unchanged.
REQ-023 abort SHALL have priority over start, and abort in IDLE SHALL have no effect.
REQ-024 Operand inputs SHALL be don't-care after capture, and changes to them SHALL NOT affect the operation in progress.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, avg=0, acc=0, idx=0, cnt=0, and clear the operand registers.
REQ-026 rst asserted mid-operation SHALL discard the operation, with no done pulse.
REQ-027 After deassertion, the first start SHALL behave exactly as in REQ-013.

Structure
REQ-028 Package avg8_ctrl_pkg SHALL hold the state enum, NUM_OPS=8, NUM_SHIFTS=3, ACC_W=32, and the IDX_W/CNT_W constants.
REQ-029 SHALL contain one sub-module, avg8_dp, holding the operand registers, the acc register and the operand mux; it SHALL instantiate the existing ADD and SHR with DATAWIDTH=32.
REQ-030 The FSM, counters, done and avg registers SHALL reside in avg8_seq_ctrl.

Verification
REQ-031 Scenario: a..h=1, sa=1, start pulse -> done 11 cycles later, avg=0x0001.
REQ-032 Scenario: a..h=0xFFFF, sa=1 -> avg=0xFFFF (proves 32-bit accumulation).
REQ-033 Scenario: a..h=1..8, sa=0 -> avg=36, and a second start raised in the done cycle completes 11 cycles later.
REQ-034 Scenario: a..h=0xFFFF, sa=11 -> avg=0; sa=255 -> avg=0.
REQ-035 Scenario: start re-asserted at E4, and a changed after capture -> result unchanged and only one done.
REQ-036 Scenario: abort at E6, and separately rst pulsed mid-SHIFT -> no done and busy=0; avg keeps its prior value after abort and is 0 after rst.
